// File: rtl/sun_pll_ctrl.sv
// sun_pll_ctrl: start-up sequencer and lock monitor for SUN_PLL (bias -> core power-up -> windowed lock check).
// Latency: a CK_REF/CK_FB edge reaches the window counters 3 CK_SYS cycles after it arrives; all outputs are registered.
// Backpressure: none; free-running monitor, EN=0 forces OFF on the next CK_SYS cycle.
//
// Ports:
//   CK_SYS      always-on system clock (>= 4x CK_REF)
//   RST         synchronous active-high reset
//   EN          PLL enable request, synchronous to CK_SYS
//   CK_REF      reference clock, asynchronous, sampled
//   CK_FB       divided feedback clock, asynchronous, sampled
//   PWRUP_BIAS  bias generator enable
//   PWRUP_1V8   PLL core power-up
//   LOCKED      PLL locked
//   FAIL        acquisition timeout
//   STATE       current FSM state (OFF=0 BIAS=1 RAMP=2 ACQ=3 LOCK=4 FAIL=5)
//   LOSS_CNT    lock-loss events, saturating at 15
`timescale 1ns/1ps
module sun_pll_ctrl #(
  parameter int SETTLE_CYC   = 64,
  parameter int RAMP_CYC     = 256,
  parameter int WIN          = 16,
  parameter int TOL          = 1,
  parameter int LOCK_WINS    = 4,
  parameter int TIMEOUT_WINS = 32
) (
  input  logic       CK_SYS,
  input  logic       RST,
  input  logic       EN,
  input  logic       CK_REF,
  input  logic       CK_FB,
  output logic       PWRUP_BIAS,
  output logic       PWRUP_1V8,
  output logic       LOCKED,
  output logic       FAIL,
  output logic [2:0] STATE,
  output logic [3:0] LOSS_CNT
);

  localparam int TMAX = (SETTLE_CYC > RAMP_CYC) ? SETTLE_CYC : RAMP_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FBW  = $clog2(2 * WIN + 1);
  localparam int RCW  = $clog2(WIN + 1);
  localparam int STW  = $clog2(LOCK_WINS + 1);
  localparam int TOW  = $clog2(TIMEOUT_WINS + 1);

  // Good-window band on the feedback edge count: WIN-TOL .. WIN+TOL.
  localparam logic [FBW-1:0] FB_LO = (TOL >= WIN) ? FBW'(0) : FBW'(WIN - TOL);
  localparam logic [FBW-1:0] FB_HI = FBW'(WIN + TOL);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_BIAS = 3'd1,
    S_RAMP = 3'd2,
    S_ACQ  = 3'd3,
    S_LOCK = 3'd4,
    S_FAIL = 3'd5
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic             r_win_open;
  logic [RCW-1:0]   r_ref_cnt;
  logic [FBW-1:0]   r_fb_cnt;
  logic [STW-1:0]   r_streak;
  logic [TOW-1:0]   r_tout;
  logic             r_pwrup_bias;
  logic             r_pwrup_1v8;
  logic             r_locked;
  logic             r_fail;
  logic [3:0]       r_loss_cnt;

  // Two-flop synchronizer plus one history flop per clock; the edge pulse
  // is registered so the input-edge-to-pulse latency is a fixed 3 cycles.
  logic [2:0]       r_ref_sync;
  logic [2:0]       r_fb_sync;
  logic             r_ref_p;
  logic             r_fb_p;

  always_ff @(posedge CK_SYS) begin
    if (RST) begin
      r_ref_sync <= '0;
      r_fb_sync  <= '0;
      r_ref_p    <= 1'b0;
      r_fb_p     <= 1'b0;
    end else begin
      r_ref_sync <= {r_ref_sync[1:0], CK_REF};
      r_fb_sync  <= {r_fb_sync[1:0], CK_FB};
      r_ref_p    <= r_ref_sync[1] & ~r_ref_sync[2];
      r_fb_p     <= r_fb_sync[1] & ~r_fb_sync[2];
    end
  end

  logic [FBW-1:0] w_fb_inc;
  logic [FBW-1:0] w_fb_total;
  logic           w_good;
  logic           w_last_ref;

  // Saturating increment; w_fb_total folds in an fb pulse coincident with
  // the current cycle so a closing ref edge sees it in the closing window.
  assign w_fb_inc   = (r_fb_cnt == {FBW{1'b1}}) ? r_fb_cnt : r_fb_cnt + 1'b1;
  assign w_fb_total = r_fb_p ? w_fb_inc : r_fb_cnt;
  assign w_good     = (w_fb_total >= FB_LO) && (w_fb_total <= FB_HI);
  assign w_last_ref = (r_ref_cnt == RCW'(WIN - 1));

  always_ff @(posedge CK_SYS) begin
    if (RST || !EN) begin
      // EN=0 behaves like reset for the sequencer: partial counts are dropped.
      r_state      <= S_OFF;
      r_timer      <= '0;
      r_win_open   <= 1'b0;
      r_ref_cnt    <= '0;
      r_fb_cnt     <= '0;
      r_streak     <= '0;
      r_tout       <= '0;
      r_pwrup_bias <= 1'b0;
      r_pwrup_1v8  <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
      r_loss_cnt   <= '0;
    end else begin
      case (r_state)
        S_OFF: begin
          r_state      <= S_BIAS;
          r_timer      <= '0;
          r_pwrup_bias <= 1'b1;
        end

        S_BIAS: begin
          if (r_timer == TW'(SETTLE_CYC - 1)) begin
            r_state     <= S_RAMP;
            r_timer     <= '0;
            r_pwrup_1v8 <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_RAMP: begin
          if (r_timer == TW'(RAMP_CYC - 1)) begin
            r_state    <= S_ACQ;
            r_timer    <= '0;
            r_win_open <= 1'b0;
            r_ref_cnt  <= '0;
            r_fb_cnt   <= '0;
            r_streak   <= '0;
            r_tout     <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_ACQ, S_LOCK: begin
          if (r_ref_p && !r_win_open) begin
            // First ref edge after ACQ entry opens the first window.
            r_win_open <= 1'b1;
            r_ref_cnt  <= '0;
            r_fb_cnt   <= '0;
          end else if (r_ref_p && w_last_ref) begin
            // Closing edge also opens the next window.
            r_ref_cnt <= '0;
            r_fb_cnt  <= '0;
            if (r_state == S_ACQ) begin
              // Lock is tested first so it wins over a simultaneous timeout.
              if (w_good && (r_streak == STW'(LOCK_WINS - 1))) begin
                r_state  <= S_LOCK;
                r_locked <= 1'b1;
                r_streak <= '0;
                r_tout   <= '0;
              end else if (r_tout == TOW'(TIMEOUT_WINS - 1)) begin
                r_state     <= S_FAIL;
                r_fail      <= 1'b1;
                r_pwrup_1v8 <= 1'b0;
              end else begin
                r_streak <= w_good ? r_streak + 1'b1 : '0;
                r_tout   <= r_tout + 1'b1;
              end
            end else if (!w_good) begin
              r_state  <= S_ACQ;
              r_locked <= 1'b0;
              r_streak <= '0;
              r_tout   <= '0;
              if (r_loss_cnt != 4'hF) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
              end
            end
          end else begin
            if (r_ref_p) begin
              r_ref_cnt <= r_ref_cnt + 1'b1;
            end
            if (r_win_open) begin
              r_fb_cnt <= w_fb_total;
            end
          end
        end

        S_FAIL: begin
          // Held until EN drops or reset.
        end

        default: begin
          r_state      <= S_OFF;
          r_pwrup_bias <= 1'b0;
          r_pwrup_1v8  <= 1'b0;
          r_locked     <= 1'b0;
          r_fail       <= 1'b0;
        end
      endcase
    end
  end

  assign PWRUP_BIAS = r_pwrup_bias;
  assign PWRUP_1V8  = r_pwrup_1v8;
  assign LOCKED     = r_locked;
  assign FAIL       = r_fail;
  assign STATE      = r_state;
  assign LOSS_CNT   = r_loss_cnt;

endmodule
